// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller slice: the occupancy state
// encoding and the default geometry of the 8 x 6-bit dual-address memory.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 6;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DEPTH      = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_e;

endpackage

// File: rtl/fifo_flags.sv
// Occupancy counter and registered status flags for fifo_ctrl.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_acc_i         a push is accepted this cycle
//   pop_acc_i          a pop is accepted this cycle
//   count_o            occupancy 0..2**ADDR_W
//   full_o, empty_o    registered full / empty
//   almost_full_o      count >= AF_TH
//   almost_empty_o     count <= AE_TH
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned AF_TH  = 6,
  parameter int unsigned AE_TH  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_acc_i,
  input  logic            pop_acc_i,
  output logic [ADDR_W:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            almost_full_o,
  output logic            almost_empty_o
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_TH);

  fifo_state_e     state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            af_q, af_d;
  logic            ae_q, ae_d;

  always_comb begin
    count_d = count_q;
    case ({push_acc_i, pop_acc_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register; flags are registered alongside it from next-cycle values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (push_acc_i && !pop_acc_i) state_d = PARTIAL;
      end
      PARTIAL: begin
        if (count_d == DEPTH_C)  state_d = FULL;
        else if (count_d == '0)  state_d = EMPTY;
      end
      FULL: begin
        if (pop_acc_i && !push_acc_i) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    full_d  = (state_d == FULL);
    empty_d = (state_d == EMPTY);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller turning a dual-address memory into a FIFO.
// Holds the read/write pointers, drives the memory strobes combinationally
// from accepted requests and registers valid_out one edge after a pop.
// Ports:
//   clk, RESET                    clock, synchronous active-high reset
//   push, data_in / pop           producer / consumer requests
//   mem_rdata                     memory read data (one cycle after mem_read)
//   mem_write, mem_address_write, mem_data   memory write side
//   mem_read, mem_address_read    memory read side
//   data_out, valid_out           dequeued word and its strobe
//   count, full, empty, almost_full, almost_empty   occupancy status
//   overflow, underflow           sticky error flags
// Build option: define FIFO_CTRL_ERR_EN to build the sticky overflow /
// underflow registers; otherwise both outputs are tied low.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned AF_TH  = 6,
  parameter int unsigned AE_TH  = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address_write,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address_read,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic              valid_q, valid_d;
  logic              push_acc;
  logic              pop_acc;

  // Gating with RESET keeps the memory strobes quiet during reset and
  // suppresses the valid_out that a pop in the reset cycle would cause.
  assign push_acc = push && !full  && !RESET;
  assign pop_acc  = pop  && !empty && !RESET;

  always_comb begin
    wp_d    = push_acc ? wp_q + 1'b1 : wp_q;
    rp_d    = pop_acc  ? rp_q + 1'b1 : rp_q;
    valid_d = pop_acc;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      valid_q <= valid_d;
    end
  end

  assign mem_write         = push_acc;
  assign mem_address_write = wp_q;
  assign mem_data          = data_in;
  assign mem_read          = pop_acc;
  assign mem_address_read  = rp_q;
  assign data_out          = mem_rdata;
  assign valid_out         = valid_q;

  fifo_flags #(
    .ADDR_W (ADDR_W),
    .AF_TH  (AF_TH),
    .AE_TH  (AE_TH)
  ) u_flags (
    .clk_i          (clk),
    .rst_i          (RESET),
    .push_acc_i     (push_acc),
    .pop_acc_i      (pop_acc),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
  );

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push && full)  ovf_q <= 1'b1;
      if (pop  && empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural 8 x 6 memory.
module tb_fifo_ctrl;

  logic       clk;
  logic       RESET;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] mem_rdata;
  logic       mem_write;
  logic [2:0] mem_address_write;
  logic [5:0] mem_data;
  logic       mem_read;
  logic [2:0] mem_address_read;
  logic [5:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  fifo_ctrl #(
    .DATA_W (6),
    .ADDR_W (3),
    .AF_TH  (6),
    .AE_TH  (2)
  ) dut (
    .clk               (clk),
    .RESET             (RESET),
    .push              (push),
    .data_in           (data_in),
    .pop               (pop),
    .mem_rdata         (mem_rdata),
    .mem_write         (mem_write),
    .mem_address_write (mem_address_write),
    .mem_data          (mem_data),
    .mem_read          (mem_read),
    .mem_address_read  (mem_address_read),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .count             (count),
    .full              (full),
    .empty             (empty),
    .almost_full       (almost_full),
    .almost_empty      (almost_empty),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle registered read.
  logic [5:0] mem [8];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address_write] <= mem_data;
    if (mem_read)  mem_rdata <= mem[mem_address_read];
  end

  typedef struct {
    bit         rst;
    bit         push;
    bit         pop;
    logic [5:0] din;
    bit         mw;
    logic [2:0] aw;
    bit         mr;
    logic [2:0] ar;
    logic [3:0] cnt;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] data_q[$];
  logic [5:0] out_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit pu, input bit po, input logic [5:0] d,
                     input bit mw, input logic [2:0] aw, input bit mr, input logic [2:0] ar,
                     input logic [3:0] c, input bit o, input bit u);
    vec_t v;
    v.rst = r; v.push = pu; v.pop = po; v.din = d;
    v.mw = mw; v.aw = aw; v.mr = mr; v.ar = ar;
    v.cnt = c; v.ovf = o; v.unf = u;
    tbl.push_back(v);
  endtask

  // Registered outputs one step after an edge, including scoreboard drain.
  task automatic chk_regs(input string tag, input logic [3:0] c, input bit o, input bit u);
    logic [5:0] e;
    bit         eo;
    bit         eu;
`ifdef FIFO_CTRL_ERR_EN
    eo = o; eu = u;
`else
    eo = 1'b0; eu = 1'b0;
`endif
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " full"}, 32'(full), 32'(c == 4'd8));
    chk({tag, " empty"}, 32'(empty), 32'(c == 4'd0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(c >= 4'd6));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 4'd2));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
    chk({tag, " underflow"}, 32'(underflow), 32'(eu));
    chk({tag, " valid_out"}, 32'(valid_out), 32'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      e = out_q.pop_front();
      if (valid_out === 1'b1) chk({tag, " data_out"}, 32'(data_out), 32'(e));
    end
  endtask

  initial begin
    // Reset with both requests asserted: strobes must stay low.
    RESET = 1'b1; push = 1'b1; pop = 1'b1; data_in = 6'h3F;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("reset mem_write", 32'(mem_write), 32'd0);
      chk("reset mem_read", 32'(mem_read), 32'd0);
      chk_regs("reset", 4'd0, 1'b0, 1'b0);
    end

    // Fill to full, then one rejected push.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 6'(i + 1), 1, 3'(i), 0, 3'd0, 4'(i + 1), 0, 0);
    add(0, 1, 0, 6'h09, 0, 3'd0, 0, 3'd0, 4'd8, 1, 0);
    // Drain with back-to-back pops; first pop carries a rejected push.
    for (int j = 0; j < 8; j++)
      add(0, (j == 0), 1, 6'h3E, 0, 3'd0, 1, 3'(j), 4'(7 - j), 1, 0);
    add(0, 0, 1, 6'h3D, 0, 3'd0, 0, 3'd0, 4'd0, 1, 1);
    // Push+pop while empty: only the push is taken.
    add(0, 1, 1, 6'h21, 1, 3'd0, 0, 3'd0, 4'd1, 1, 1);
    add(0, 1, 0, 6'h22, 1, 3'd1, 0, 3'd0, 4'd2, 1, 1);
    add(0, 1, 0, 6'h23, 1, 3'd2, 0, 3'd0, 4'd3, 1, 1);
    // Simultaneous push/pop at count 3.
    add(0, 1, 1, 6'h0C, 1, 3'd3, 1, 3'd0, 4'd3, 1, 1);
    for (int j = 0; j < 3; j++) add(0, 0, 1, 6'h00, 0, 3'd4, 1, 3'(j + 1), 4'(2 - j), 1, 1);
    add(1, 0, 0, 6'h00, 0, 3'd4, 0, 3'd4, 4'd0, 0, 0);
    // Wrap: 5 pushes, 5 pops, 5 pushes.
    for (int i = 0; i < 5; i++) add(0, 1, 0, 6'(49 + i), 1, 3'(i), 0, 3'd0, 4'(i + 1), 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 6'h00, 0, 3'd5, 1, 3'(i), 4'(4 - i), 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 6'(54 + i), 1, 3'(5 + i), 0, 3'd5, 4'(i + 1), 0, 0);
    add(0, 0, 1, 6'h00, 0, 3'd2, 1, 3'd5, 4'd4, 0, 0);
    // Reset at count 4 with pop and push requested.
    add(1, 1, 1, 6'h11, 0, 3'd2, 0, 3'd6, 4'd0, 0, 0);
    add(0, 0, 0, 6'h2A, 0, 3'd0, 0, 3'd0, 4'd0, 0, 0);
    // Push at edge N popped at N+1.
    add(0, 1, 0, 6'h15, 1, 3'd0, 0, 3'd0, 4'd1, 0, 0);
    add(0, 0, 1, 6'h00, 0, 3'd1, 1, 3'd0, 4'd0, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      vec_t  v;
      string tag;
      v   = tbl[n];
      tag = $sformatf("row%0d", n);
      RESET = v.rst; push = v.push; pop = v.pop; data_in = v.din;
      #1;
      chk({tag, " mem_write"}, 32'(mem_write), 32'(v.mw));
      chk({tag, " mem_address_write"}, 32'(mem_address_write), 32'(v.aw));
      chk({tag, " mem_read"}, 32'(mem_read), 32'(v.mr));
      chk({tag, " mem_address_read"}, 32'(mem_address_read), 32'(v.ar));
      chk({tag, " mem_data"}, 32'(mem_data), 32'(v.din));
      if (v.rst) begin
        data_q.delete();
      end else begin
        if (v.mr && data_q.size() != 0) out_q.push_back(data_q.pop_front());
        if (v.mw) data_q.push_back(v.din);
      end
      @(posedge clk);
      #1;
      chk_regs(tag, v.cnt, v.ovf, v.unf);
    end

    // Idle cycle after the last pop: valid_out must drop.
    RESET = 1'b0; push = 1'b0; pop = 1'b0; data_in = 6'h00;
    @(posedge clk);
    #1;
    chk_regs("idle", 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that turns the 8-entry × 6-bit dual-address memory into a FIFO. It sits directly upstream of the memory:
- accepts push/pop requests from the producing and consuming stages;
- generates the memory's `write`/`address_write`/`data` and `read`/`address_read` strobes;
- tracks occupancy and full/empty/almost flags;
- returns popped words with a valid strobe aligned to the memory's read latency.

## Interface
Parameters:
- `DATA_W`, 6, word width; matches memory `data`.
- `ADDR_W`, 3, memory address width; depth = 2**ADDR_W = 8.
- `AF_TH`, 6, `almost_full` asserts when count ≥ AF_TH.
- `AE_TH`, 2, `almost_empty` asserts when count ≤ AE_TH.

Ports:
- `clk` in 1: single clock; all logic samples on posedge.
- `RESET` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `push` in 1: producer request to write `data_in`.
- `data_in` in DATA_W: word to enqueue.
- `pop` in 1: consumer request to dequeue.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_read`.
- `mem_write` out 1: memory write enable.
- `mem_address_write` out ADDR_W: memory write address.
- `mem_data` out DATA_W: memory write data.
- `mem_read` out 1: memory read enable.
- `mem_address_read` out ADDR_W: memory read address.
- `data_out` out DATA_W: dequeued word.
- `valid_out` out 1: `data_out` valid this cycle.
- `count` out ADDR_W+1: occupancy, 0..8.
- `full`, `empty`, `almost_full`, `almost_empty` out 1: status flags.
- `overflow`, `underflow` out 1: sticky error flags (see Configuration).

## Operation
- Internal write pointer `wp`, read pointer `rp`, both ADDR_W bits, wrap 7→0 naturally.
- Push accept: `push && !full`.
  - Same-cycle, combinational: `mem_write`=1, `mem_address_write`=`wp`, `mem_data`=`data_in`.
  - Next edge: `wp`++.
- Pop accept: `pop && !empty`.
  - Same-cycle, combinational: `mem_read`=1, `mem_address_read`=`rp`.
  - Next edge: `rp`++.
- Rejected requests drive no memory strobe.
- While idle, `mem_address_*` hold the current pointers and `mem_data`=`data_in`.
- Push with full: rejected regardless of `pop`. Pop with empty: rejected regardless of `push`.
- Simultaneous accepted push and pop: both pointers advance and `count` is unchanged. `wp`≠`rp` is guaranteed in this case because the FIFO is neither empty nor full.
- `count` update on the next edge:
  - +1 on push-only accept;
  - −1 on pop-only accept;
  - unchanged otherwise.
- Flags are registered and derived from the next `count`:
  - `full` = (count==8)
  - `empty` = (count==0)
  - `almost_full` = (count≥AF_TH)
  - `almost_empty` = (count≤AE_TH)
- State machine: `EMPTY` / `PARTIAL` / `FULL`, encoded from `count`.
  - `EMPTY`→`PARTIAL` on push.
  - `PARTIAL`→`FULL` when count reaches 8.
  - `PARTIAL`→`EMPTY` when count reaches 0.
  - `FULL`→`PARTIAL` on pop.
  - A state self-loops on simultaneous push/pop, and in `EMPTY`/`FULL` on rejected requests.
- `valid_out` is a register set to 1 on the edge after an accepted pop, otherwise 0. `data_out` = `mem_rdata`, passed through combinationally.

## Timing
- Reset values, applied when `RESET` is high at an edge:
  - `wp`=`rp`=0, `count`=0, state `EMPTY`;
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0;
  - `valid_out`=0, `overflow`=`underflow`=0.
- Reset overrides `push`/`pop` in the same cycle. `mem_write`/`mem_read` are forced to 0 while `RESET` is high.
- Reset mid-stream discards contents. A `valid_out` pending from a pop in the reset cycle is suppressed.
- Latency:
  - push to visible `count`/flag change: 1 edge;
  - push at edge N can be popped at edge N+1;
  - pop request to `valid_out`: 1 edge.
- Back-to-back pops every cycle give `valid_out` high every cycle, one cycle delayed.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `overflow` sets on push while full;
  - `underflow` sets on pop while empty;
  - both are sticky until `RESET`.
- `FIFO_CTRL_ERR_EN` undefined: `overflow` and `underflow` are tied to 0 and no error registers are built. Ports remain present.

## Structure
- Shared package `fifo_pkg`:
  - state enum `{EMPTY, PARTIAL, FULL}`;
  - `DATA_W` and `ADDR_W` defaults;
  - `DEPTH` constant.
- One natural sub-module: `fifo_flags`, which computes next `count` and registered flags from push/pop accept. The top level holds pointers, memory strobes and `valid_out`.

## Test plan
- Reset, then 8 pushes of 0x01..0x08 with `pop`=0:
  - `mem_address_write` runs 0..7;
  - `almost_full` rises after the 6th push, `full` after the 8th;
  - 9th push: no `mem_write`, `overflow`=1 (with EN).
- From full, 8 pops:
  - `mem_address_read` runs 0..7;
  - `valid_out` each following cycle with `data_out` 0x01..0x08;
  - `empty`=1 after the last pop;
  - extra pop: no `mem_read`, `underflow`=1.
- Push 0x0C at count 3 with a simultaneous pop: `count` stays 3, both pointers advance, popped data is the oldest word.
- Wrap: 5 pushes, 5 pops, 5 pushes. Writes wrap to addresses 5,6,7,0,1; reads return the pushed order.
- Push+pop while empty: push accepted, pop rejected, `count`=1, no `valid_out`.
- Assert `RESET` at count 4 with a pop in flight: next cycle `count`=0, `empty`=1, `valid_out`=0, pointers 0.
